// File: rtl/vote_controller.sv
// vote_controller: ballot sequencer between the candidate button debouncers and
// the result display. Arms one ballot per officer enable, records exactly one
// unambiguous vote per ballot, locks out for LOCK_CYCLES cycles afterwards and
// keeps saturating per-candidate and total tallies.
//
// Ports:
//   clock         system clock, all logic on posedge
//   reset         asynchronous active-low reset
//   mode          0 = voting mode, 1 = result mode
//   ballot_enable officer pulse that arms one ballot
//   valid_vote    debounced one-cycle vote pulses, bit i = candidate i
//   clear_counts  clear all tallies (result mode, IDLE only)
//   sel           candidate index for count_out
//   armed         ballot armed, awaiting a vote
//   busy          recording or in lockout
//   vote_ack      one-cycle pulse when a vote is recorded
//   vote_id       index of the last recorded candidate
//   multi_press   one-cycle pulse, ambiguous press rejected
//   overflow      sticky, a tally saturated
//   count_out     tally of candidate sel (result mode only, else 0)
//   total_out     total recorded votes (result mode only, else 0)
module vote_controller #(
  parameter int unsigned NUM_CAND    = 4,
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned TOTAL_W     = 10,
  parameter int unsigned LOCK_CYCLES = 100000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                ballot_enable,
  input  logic [NUM_CAND-1:0] valid_vote,
  input  logic                clear_counts,
  input  logic [2:0]          sel,
  output logic                armed,
  output logic                busy,
  output logic                vote_ack,
  output logic [2:0]          vote_id,
  output logic                multi_press,
  output logic                overflow,
  output logic [COUNT_W-1:0]  count_out,
  output logic [TOTAL_W-1:0]  total_out
);

  localparam int unsigned TIMER_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RECORD,
    S_HOLD
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [TIMER_W-1:0]  r_timer;
  logic [COUNT_W-1:0]  r_count [NUM_CAND];
  logic [TOTAL_W-1:0]  r_total;
  logic [2:0]          r_vote_id;
  logic                r_multi;
  logic                r_overflow;
  logic [COUNT_W-1:0]  r_count_out;
  logic [TOTAL_W-1:0]  r_total_out;

  logic                w_onehot;
  logic                w_multi;
  logic [2:0]          w_vote_idx;
  logic                w_capture;
  logic                w_reject;
  logic                w_clear;
  logic [COUNT_W-1:0]  w_count_sel;

  // Decode the pressed candidate and the tally selected for display.
  // sel values beyond NUM_CAND match nothing and read as zero.
  always_comb begin
    w_onehot    = $onehot(valid_vote);
    w_multi     = (valid_vote != '0) && !w_onehot;
    w_vote_idx  = '0;
    w_count_sel = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (valid_vote[i]) w_vote_idx = 3'(i);
      if (sel == 3'(i))  w_count_sel = r_count[i];
    end
  end

  // Mode takes priority over any press while armed.
  always_comb begin
    w_capture = (r_state == S_ARMED) && !mode && w_onehot;
    w_reject  = (r_state == S_ARMED) && !mode && w_multi;
    w_clear   = (r_state == S_IDLE) && mode && clear_counts;
    w_next    = r_state;
    unique case (r_state)
      S_IDLE:   if (ballot_enable && !mode) w_next = S_ARMED;
      S_ARMED: begin
        if (mode)          w_next = S_IDLE;
        else if (w_onehot) w_next = S_RECORD;
      end
      S_RECORD: w_next = S_HOLD;
      S_HOLD:   if (r_timer == '0) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timer     <= '0;
      r_total     <= '0;
      r_vote_id   <= '0;
      r_multi     <= 1'b0;
      r_overflow  <= 1'b0;
      r_count_out <= '0;
      r_total_out <= '0;
      for (int unsigned i = 0; i < NUM_CAND; i++) r_count[i] <= '0;
    end else begin
      r_multi <= w_reject;
      // The captured index doubles as the registered vote_id, so it is valid
      // in the same cycle as vote_ack.
      if (w_capture) r_vote_id <= w_vote_idx;

      if (r_state == S_RECORD) begin
        r_timer <= TIMER_W'(LOCK_CYCLES - 1);
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
          if (r_vote_id == 3'(i)) begin
            if (r_count[i] == '1) r_overflow <= 1'b1;
            else                  r_count[i] <= r_count[i] + COUNT_W'(1);
          end
        end
        if (r_total == '1) r_overflow <= 1'b1;
        else               r_total    <= r_total + TOTAL_W'(1);
      end else if (r_state == S_HOLD && r_timer != '0) begin
        r_timer <= r_timer - TIMER_W'(1);
      end

      if (w_clear) begin
        r_total    <= '0;
        r_overflow <= 1'b0;
        for (int unsigned i = 0; i < NUM_CAND; i++) r_count[i] <= '0;
      end

      r_count_out <= mode ? w_count_sel : '0;
      r_total_out <= mode ? r_total : '0;
    end
  end

  assign armed       = (r_state == S_ARMED);
  assign busy        = (r_state == S_RECORD) || (r_state == S_HOLD);
  assign vote_ack    = (r_state == S_RECORD);
  assign vote_id     = r_vote_id;
  assign multi_press = r_multi;
  assign overflow    = r_overflow;
  assign count_out   = r_count_out;
  assign total_out   = r_total_out;

endmodule
